decode_issue_stage: RTL and testbench

//  Issue point at the end of decode: holds a decoded instruction until its source registers have no

---
 rtl/issue_pkg.sv | 27 ++
 rtl/reg_scoreboard.sv | 73 +++++++
 rtl/decode_issue_stage.sv | 83 ++++++++
 tb/tb_decode_issue_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and sizing for the decode issue stage and its write scoreboard.
// Scalar source reads arrive already replicated across every vector element.
package issue_pkg;

    localparam int REG_SIZE  = 16;
    localparam int VEC_SIZE  = 4;
    localparam int SEL_BITS  = 5;
    localparam int CNT_BITS  = 2;
    localparam int CTRL_BITS = 8;
    localparam int NUM_REGS  = 2 ** SEL_BITS;

    typedef logic [SEL_BITS-1:0]                reg_idx_t;
    typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vec_t;
    typedef logic [CTRL_BITS-1:0]               ctrl_t;
    typedef logic [CNT_BITS-1:0]                cnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef struct packed {
        ctrl_t    ctrl;
        logic     regWrEn;
        reg_idx_t regToWrite;
        vec_t     op1;
        vec_t     op2;
    } issue_pkt_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of issued-but-not-retired writes; reports busy sources and full destinations.
// Counters update one cycle after inc/dec; lookups are combinational on registered counts.
module reg_scoreboard
    import issue_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  reg_idx_t rd_sel1,
    input  reg_idx_t rd_sel2,
    input  reg_idx_t rd_dest,
    output logic     busy1,
    output logic     busy2,
    output logic     dest_full,
    input  logic     inc_vld,
    input  reg_idx_t inc_reg,
    input  logic     wb_vld,
    input  reg_idx_t wb_reg,
    input  logic     fl_vld,
    input  reg_idx_t fl_reg
);

    cnt_t                cnt     [NUM_REGS];
    cnt_t                cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] underflow;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        logic                   inc;
        logic                   dec_wb;
        logic                   dec_fl;
        logic signed [CNT_BITS+1:0] sum;
        cnt_t                   nxt;

        assign inc    = inc_vld && (inc_reg == reg_idx_t'(r));
        assign dec_wb = wb_vld  && (wb_reg  == reg_idx_t'(r));
        assign dec_fl = fl_vld  && (fl_reg  == reg_idx_t'(r));

        // Two guard bits: the sign bit catches underflow, the next one anything above CNT_MAX.
        assign sum = $signed({2'b00, cnt[r]})
                   + $signed({{(CNT_BITS+1){1'b0}}, inc})
                   - $signed({{(CNT_BITS+1){1'b0}}, dec_wb})
                   - $signed({{(CNT_BITS+1){1'b0}}, dec_fl});

        always_comb begin
            nxt = sum[CNT_BITS-1:0];
            if (sum[CNT_BITS+1]) begin
                nxt = '0;
            end else if (sum[CNT_BITS]) begin
                nxt = CNT_MAX;
            end
        end

        assign cnt_nxt[r]   = nxt;
        assign underflow[r] = sum[CNT_BITS+1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '{default: '0};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    assign busy1     = (cnt[rd_sel1] != '0);
    assign busy2     = (cnt[rd_sel2] != '0);
    assign dest_full = (cnt[rd_dest] == CNT_MAX);

    // A retirement against an idle register means upstream lost track of its writes.
    assert property (@(posedge clk) disable iff (!reset) underflow == '0);

endmodule

// File: rtl/decode_issue_stage.sv
// Holds a decoded instruction until its sources have no pending writes, then registers it for execute.
// One cycle accept-to-out_valid; in_ready drops on hazard, full destination, flush or occupied slot.
module decode_issue_stage
    import issue_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_BITS-1:0]          in_rSel1,
    input  logic [SEL_BITS-1:0]          in_rSel2,
    input  logic                         in_use1,
    input  logic                         in_use2,
    input  logic                         in_regWrEn,
    input  logic [SEL_BITS-1:0]          in_regToWrite,
    input  logic [CTRL_BITS-1:0]         in_ctrl,
    input  logic [VEC_SIZE*REG_SIZE-1:0] operand1,
    input  logic [VEC_SIZE*REG_SIZE-1:0] operand2,
    input  logic                         wb_valid,
    input  logic [SEL_BITS-1:0]          wb_reg,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VEC_SIZE*REG_SIZE-1:0] out_op1,
    output logic [VEC_SIZE*REG_SIZE-1:0] out_op2,
    output logic [CTRL_BITS-1:0]         out_ctrl,
    output logic                         out_regWrEn,
    output logic [SEL_BITS-1:0]          out_regToWrite,
    output logic                         stall
);

    issue_pkt_t pkt;
    logic       busy1;
    logic       busy2;
    logic       dest_full;
    logic       hazard;
    logic       slot_free;
    logic       issue;

    reg_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .rd_sel1   (in_rSel1),
        .rd_sel2   (in_rSel2),
        .rd_dest   (in_regToWrite),
        .busy1     (busy1),
        .busy2     (busy2),
        .dest_full (dest_full),
        .inc_vld   (issue && in_regWrEn),
        .inc_reg   (in_regToWrite),
        .wb_vld    (wb_valid),
        .wb_reg    (wb_reg),
        .fl_vld    (flush && out_valid && pkt.regWrEn),
        .fl_reg    (pkt.regToWrite)
    );

    // Registered counts only: a writeback this cycle still blocks, its data lands at this edge.
    assign hazard    = (in_use1 && busy1) || (in_use2 && busy2) || (in_regWrEn && dest_full);
    assign slot_free = !out_valid || (out_ready && !flush);
    assign in_ready  = reset && slot_free && !hazard && !flush;
    assign issue     = in_valid && in_ready;
    assign stall     = in_valid && !in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            pkt       <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            pkt       <= '{ctrl: in_ctrl, regWrEn: in_regWrEn, regToWrite: in_regToWrite,
                           op1: vec_t'(operand1), op2: vec_t'(operand2)};
        end else if (out_ready || flush) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op1        = pkt.op1;
    assign out_op2        = pkt.op2;
    assign out_ctrl       = pkt.ctrl;
    assign out_regWrEn    = pkt.regWrEn;
    assign out_regToWrite = pkt.regToWrite;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: table of single-cycle issue vectors plus hand-written
// sequences for RAW, back-pressure, flush, counter saturation and mid-run reset.
module tb_decode_issue_stage;
    import issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rSel1;
    logic [4:0]  in_rSel2;
    logic        in_use1;
    logic        in_use2;
    logic        in_regWrEn;
    logic [4:0]  in_regToWrite;
    logic [7:0]  in_ctrl;
    logic [63:0] operand1;
    logic [63:0] operand2;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_op1;
    logic [63:0] out_op2;
    logic [7:0]  out_ctrl;
    logic        out_regWrEn;
    logic [4:0]  out_regToWrite;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    decode_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rSel1(in_rSel1), .in_rSel2(in_rSel2), .in_use1(in_use1), .in_use2(in_use2),
        .in_regWrEn(in_regWrEn), .in_regToWrite(in_regToWrite), .in_ctrl(in_ctrl),
        .operand1(operand1), .operand2(operand2), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1),
        .out_op2(out_op2), .out_ctrl(out_ctrl), .out_regWrEn(out_regWrEn),
        .out_regToWrite(out_regToWrite), .stall(stall)
    );

    always #5 clk = ~clk;

    // Register-file model: each index yields a distinctive replicated pattern per port.
    function automatic logic [63:0] rf1(input logic [4:0] s);
        return {4{11'h500, s}};
    endfunction
    function automatic logic [63:0] rf2(input logic [4:0] s);
        return {4{11'h3C0, s}};
    endfunction

    assign operand1 = rf1(in_rSel1);
    assign operand2 = rf2(in_rSel2);

    function automatic logic [1:0] cnt_of(input int i);
        return dut.u_sb.cnt[i];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic we, input logic [4:0] rd, input logic [7:0] ctrl);
        in_valid      = v;
        in_rSel1      = rs1;
        in_use1       = u1;
        in_rSel2      = rs2;
        in_use2       = u2;
        in_regWrEn    = we;
        in_regToWrite = rd;
        in_ctrl       = ctrl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       we;
        logic [4:0] rd;
        logic [7:0] ctrl;
        logic       exp_rdy;
        logic       exp_stall;
    } vec_rec_t;

    vec_rec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- reset with an instruction presented ----
        reset     = 1'b0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_reg    = 5'd0;
        out_ready = 1'b1;
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 8'h5A);
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_op1", out_op1, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_we", 64'(out_regWrEn), 64'd0);
        idle();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rst_cnt%0d", i), 64'(cnt_of(i)), 64'd0);
        end
        tick();

        // ---- table-driven single-cycle issue vectors, out_ready=1 ----
        tbl[0] = '{1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1,  8'h11, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 5'd4,  8'h22, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 5'd1, 1'b0, 5'd4, 1'b0, 1'b1, 5'd10, 8'h33, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0,  8'h44, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 5'd8, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0,  8'h55, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 5'd3,  8'h66, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].we, tbl[i].rd,
                  tbl[i].ctrl);
            #2;
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].exp_stall));
            tick();
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].v & tbl[i].exp_rdy));
            if (tbl[i].v && tbl[i].exp_rdy) begin
                chk($sformatf("tbl%0d_op1", i), out_op1, rf1(tbl[i].rs1));
                chk($sformatf("tbl%0d_op2", i), out_op2, rf2(tbl[i].rs2));
                chk($sformatf("tbl%0d_ctrl", i), 64'(out_ctrl), 64'(tbl[i].ctrl));
                chk($sformatf("tbl%0d_we", i), 64'(out_regWrEn), 64'(tbl[i].we));
                chk($sformatf("tbl%0d_rd", i), 64'(out_regToWrite), 64'(tbl[i].rd));
            end
        end
        idle();
        chk("tbl_cnt1", 64'(cnt_of(1)), 64'd1);
        chk("tbl_cnt4", 64'(cnt_of(4)), 64'd1);
        chk("tbl_cnt10", 64'(cnt_of(10)), 64'd1);
        chk("tbl_cnt3", 64'(cnt_of(3)), 64'd0);
        wb_valid = 1'b1;
        wb_reg   = 5'd1;
        tick();
        wb_reg = 5'd4;
        tick();
        wb_reg = 5'd10;
        tick();
        wb_valid = 1'b0;
        chk("retire_cnt1", 64'(cnt_of(1)), 64'd0);
        chk("retire_cnt4", 64'(cnt_of(4)), 64'd0);
        chk("retire_cnt10", 64'(cnt_of(10)), 64'd0);

        // ---- RAW on r7 ----
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 8'h71);
        #2;
        chk("raw_prod_in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 8'h72);
        #2;
        chk("raw_stall_a", 64'(stall), 64'd1);
        tick();
        #2;
        chk("raw_stall_b", 64'(stall), 64'd1);
        tick();
        wb_valid = 1'b1;
        wb_reg   = 5'd7;
        #2;
        chk("raw_stall_wb", 64'(stall), 64'd1);
        tick();
        wb_valid = 1'b0;
        #2;
        chk("raw_stall_after", 64'(stall), 64'd0);
        chk("raw_in_ready_after", 64'(in_ready), 64'd1);
        tick();
        idle();
        chk("raw_out_valid", 64'(out_valid), 64'd1);
        chk("raw_op1", out_op1, rf1(5'd7));
        chk("raw_ctrl", 64'(out_ctrl), 64'h72);
        chk("raw_cnt7", 64'(cnt_of(7)), 64'd0);
        tick();

        // ---- back-pressure ----
        drive(1'b1, 5'd11, 1'b1, 5'd14, 1'b1, 1'b1, 5'd12, 8'hAA);
        #2;
        tick();
        out_ready = 1'b0;
        drive(1'b1, 5'd15, 1'b1, 5'd16, 1'b1, 1'b1, 5'd13, 8'hBB);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
            chk($sformatf("bp%0d_stall", k), 64'(stall), 64'd1);
            tick();
            chk($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d_op1", k), out_op1, rf1(5'd11));
            chk($sformatf("bp%0d_ctrl", k), 64'(out_ctrl), 64'hAA);
            chk($sformatf("bp%0d_cnt12", k), 64'(cnt_of(12)), 64'd1);
            chk($sformatf("bp%0d_cnt13", k), 64'(cnt_of(13)), 64'd0);
        end
        out_ready = 1'b1;
        #2;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        idle();
        chk("bp_release_ctrl", 64'(out_ctrl), 64'hBB);
        chk("bp_release_op2", out_op2, rf2(5'd16));
        chk("bp_release_cnt13", 64'(cnt_of(13)), 64'd1);
        wb_valid = 1'b1;
        wb_reg   = 5'd12;
        tick();
        wb_reg = 5'd13;
        tick();
        wb_valid = 1'b0;
        chk("bp_drain_cnt12", 64'(cnt_of(12)), 64'd0);
        chk("bp_drain_cnt13", 64'(cnt_of(13)), 64'd0);

        // ---- flush of a held write ----
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 8'h91);
        #2;
        tick();
        idle();
        chk("fl_cnt9_held", 64'(cnt_of(9)), 64'd1);
        flush = 1'b1;
        #2;
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_cnt9", 64'(cnt_of(9)), 64'd0);
        // flush + wb + competing issue to r9 in one cycle
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 8'h92);
        #2;
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 8'h93);
        #2;
        chk("fl2_second_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("fl2_cnt9_two", 64'(cnt_of(9)), 64'd2);
        chk("fl2_held_ctrl", 64'(out_ctrl), 64'h93);
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_reg   = 5'd9;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 8'h94);
        #2;
        chk("fl2_in_ready", 64'(in_ready), 64'd0);
        chk("fl2_stall", 64'(stall), 64'd1);
        tick();
        flush    = 1'b0;
        wb_valid = 1'b0;
        idle();
        chk("fl2_cnt9", 64'(cnt_of(9)), 64'd0);
        chk("fl2_out_valid", 64'(out_valid), 64'd0);
        chk("fl2_ctrl_kept", 64'(out_ctrl), 64'h93);

        // ---- destination counter saturation on r2 ----
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 8'hC0 + 8'(k));
            #2;
            chk($sformatf("sat%0d_in_ready", k), 64'(in_ready), 64'd1);
            tick();
        end
        chk("sat_cnt2_full", 64'(cnt_of(2)), 64'd3);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 8'hC3);
        #2;
        chk("sat_stall", 64'(stall), 64'd1);
        tick();
        wb_valid = 1'b1;
        wb_reg   = 5'd2;
        #2;
        chk("sat_stall_wb", 64'(stall), 64'd1);
        tick();
        wb_valid = 1'b0;
        chk("sat_cnt2_after_wb", 64'(cnt_of(2)), 64'd2);
        #2;
        chk("sat_stall_clear", 64'(stall), 64'd0);
        tick();
        idle();
        chk("sat_cnt2_refill", 64'(cnt_of(2)), 64'd3);
        chk("sat_ctrl", 64'(out_ctrl), 64'hC3);
        chk("sat_out_valid", 64'(out_valid), 64'd1);

        // ---- reset mid-operation ----
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cnt2", 64'(cnt_of(2)), 64'd0);
        chk("mid_rst_ctrl", 64'(out_ctrl), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
